inst_queue_2way: RTL and testbench

Two-wide instruction queue between the fetch unit and the dual decoders (way0/way1). Accepts up to two fetched instructions per cycle, buffers them in order in a circular buffer, and presents the two oldest entries to the way0 and way1 decoders with a valid/ready handshake. Flush support lets the pipeline discard all buffered instructions on redirect.

---
 rtl/inst_queue_pkg.sv | 29 ++
 rtl/inst_queue_ram.sv | 48 ++++
 rtl/inst_queue_2way.sv | 146 ++++++++++++++
 tb/tb_inst_queue_2way.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/inst_queue_pkg.sv
// -----------------------------------------------------------------------------
// inst_queue_pkg
// Shared definitions for the two-wide instruction queue.
//   INST_NOP          : instruction driven on empty decoder slots (addi x0,x0,0)
//   IQ_DEPTH_DEFAULT  : default queue depth
//   iq_entry_t        : one queue entry (instruction, plus address when the
//                       INST_ADDR_TRACE_EN macro is defined)
// -----------------------------------------------------------------------------
package inst_queue_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam int          IQ_DEPTH_DEFAULT = 8;

    typedef struct packed {
`ifdef INST_ADDR_TRACE_EN
        logic [31:0] addr;
`endif
        logic [31:0] inst;
    } iq_entry_t;

    // Entry as seen on an empty decoder slot: NOP with a zero address.
    function automatic iq_entry_t iq_empty_entry();
        iq_entry_t e;
        e      = '0;
        e.inst = INST_NOP;
        return e;
    endfunction

endpackage

// File: rtl/inst_queue_ram.sv
// -----------------------------------------------------------------------------
// inst_queue_ram
// DEPTH x iq_entry_t storage for the instruction queue. Two synchronous write
// ports and two asynchronous read ports. No reset: contents are only ever
// observed through the pointer/count logic in the parent, which masks stale
// entries.
// Ports:
//   clk                      core clock
//   we0_i/waddr0_i/wdata0_i  write port 0
//   we1_i/waddr1_i/wdata1_i  write port 1 (wins on a same-index collision)
//   raddr0_i/rdata0_o        read port 0 (combinational)
//   raddr1_i/rdata1_o        read port 1 (combinational)
// -----------------------------------------------------------------------------
module inst_queue_ram
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            we0_i,
    input  logic [PW-1:0]   waddr0_i,
    input  iq_entry_t       wdata0_i,
    input  logic            we1_i,
    input  logic [PW-1:0]   waddr1_i,
    input  iq_entry_t       wdata1_i,
    input  logic [PW-1:0]   raddr0_i,
    output iq_entry_t       rdata0_o,
    input  logic [PW-1:0]   raddr1_i,
    output iq_entry_t       rdata1_o
);

    iq_entry_t mem_q [DEPTH];

    // Port 1 is written last so it takes precedence on the same index.
    always_ff @(posedge clk) begin
        if (we0_i) begin
            mem_q[waddr0_i] <= wdata0_i;
        end
        if (we1_i) begin
            mem_q[waddr1_i] <= wdata1_i;
        end
    end

    assign rdata0_o = mem_q[raddr0_i];
    assign rdata1_o = mem_q[raddr1_i];

endmodule

// File: rtl/inst_queue_2way.sv
// -----------------------------------------------------------------------------
// inst_queue_2way
// Two-wide in-order instruction queue between fetch and the way0/way1 decoders.
// Up to two instructions are pushed per cycle into a circular buffer; the two
// oldest entries are presented to the decoders. Flush empties the queue.
// Optional feature macro: INST_ADDR_TRACE_EN adds a 32-bit address per entry
// and the inAddr*/way*Addr trace ports.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   flush_i                      discard all entries, including this cycle's push
//   inVld0_i/inVld1_i            fetch slot valids (slot 1 only counts with slot 0)
//   inInst0_i/inInst1_i          fetched instructions, slot 0 older
//   inReady_o                    room for two instructions (registered state only)
//   way0Vld_o/way1Vld_o          head / head+1 entry valid
//   way0Inst_o/way1Inst_o        instructions to decoders (NOP when invalid)
//   way0Ready_i/way1Ready_i      decoder consumes its slot
//   count_o                      occupied entries
//   inAddr*_i/way*Addr_o         trace addresses (INST_ADDR_TRACE_EN only)
// -----------------------------------------------------------------------------
module inst_queue_2way
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH_DEFAULT,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush_i,
    input  logic            inVld0_i,
    input  logic            inVld1_i,
    input  logic [31:0]     inInst0_i,
    input  logic [31:0]     inInst1_i,
`ifdef INST_ADDR_TRACE_EN
    input  logic [31:0]     inAddr0_i,
    input  logic [31:0]     inAddr1_i,
    output logic [31:0]     way0Addr_o,
    output logic [31:0]     way1Addr_o,
`endif
    output logic            inReady_o,
    output logic            way0Vld_o,
    output logic            way1Vld_o,
    output logic [31:0]     way0Inst_o,
    output logic [31:0]     way1Inst_o,
    input  logic            way0Ready_i,
    input  logic            way1Ready_i,
    output logic [CW-1:0]   count_o
);

    // (DEPTH - count) >= 2 rewritten as count <= DEPTH-2 to stay unsigned.
    localparam logic [CW-1:0] FILL_LIMIT = CW'(DEPTH - 2);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic          push0, push1, pop0, pop1;
    logic [1:0]    pushNum, popNum;
    iq_entry_t     wr0, wr1, rd0, rd1;
    logic [PW-1:0] head_p1, tail_p1;

    // Handshake: everything below depends on registered state plus the
    // request inputs, never on the other side of the queue.
    assign inReady_o = (count_q <= FILL_LIMIT);
    assign way0Vld_o = (count_q != '0);
    assign way1Vld_o = (count_q >= CW'(2));

    // Slot 1 is ignored unless slot 0 is also valid.
    assign push0 = inReady_o & inVld0_i;
    assign push1 = inReady_o & inVld0_i & inVld1_i;
    assign pop0  = way0Vld_o & way0Ready_i;
    assign pop1  = pop0 & way1Vld_o & way1Ready_i;

    assign pushNum = {1'b0, push0} + {1'b0, push1};
    assign popNum  = {1'b0, pop0} + {1'b0, pop1};

    // Power-of-two depth: pointer arithmetic wraps naturally.
    assign head_p1 = head_q + PW'(1);
    assign tail_p1 = tail_q + PW'(1);

    always_comb begin
        head_d  = head_q + PW'(popNum);
        tail_d  = tail_q + PW'(pushNum);
        count_d = count_q + CW'(pushNum) - CW'(popNum);
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        wr0      = '0;
        wr1      = '0;
        wr0.inst = inInst0_i;
        wr1.inst = inInst1_i;
`ifdef INST_ADDR_TRACE_EN
        wr0.addr = inAddr0_i;
        wr1.addr = inAddr1_i;
`endif
    end

    inst_queue_ram #(
        .DEPTH    (DEPTH)
    ) u_ram (
        .clk      (clk),
        .we0_i    (push0 & ~flush_i & ~rst),
        .waddr0_i (tail_q),
        .wdata0_i (wr0),
        .we1_i    (push1 & ~flush_i & ~rst),
        .waddr1_i (tail_p1),
        .wdata1_i (wr1),
        .raddr0_i (head_q),
        .rdata0_o (rd0),
        .raddr1_i (head_p1),
        .rdata1_o (rd1)
    );

    // Invalid slots are masked so stale or uninitialised storage never
    // reaches the decoders.
    iq_entry_t out0, out1;
    assign out0 = way0Vld_o ? rd0 : iq_empty_entry();
    assign out1 = way1Vld_o ? rd1 : iq_empty_entry();

    assign way0Inst_o = out0.inst;
    assign way1Inst_o = out1.inst;
`ifdef INST_ADDR_TRACE_EN
    assign way0Addr_o = out0.addr;
    assign way1Addr_o = out1.addr;
`endif

    assign count_o = count_q;

endmodule

// File: tb/tb_inst_queue_2way.sv
module tb_inst_queue_2way;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] A   = 32'h0050_0093;
    localparam logic [31:0] B   = 32'h0010_0113;
    localparam logic [31:0] C   = 32'h0000_0C0C;
    localparam logic [31:0] D   = 32'h0000_0D0D;
    localparam logic [31:0] E   = 32'h0000_0E0E;
    localparam logic [31:0] F   = 32'h0000_0F0F;
    localparam logic [31:0] G   = 32'h0000_0513;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush_i = 1'b0;
    logic        inVld0_i = 1'b0, inVld1_i = 1'b0;
    logic [31:0] inInst0_i = '0, inInst1_i = '0;
    logic        inReady_o, way0Vld_o, way1Vld_o;
    logic [31:0] way0Inst_o, way1Inst_o;
    logic        way0Ready_i = 1'b0, way1Ready_i = 1'b0;
    logic [3:0]  count_o;
`ifdef INST_ADDR_TRACE_EN
    logic [31:0] inAddr0_i = '0, inAddr1_i = '0;
    logic [31:0] way0Addr_o, way1Addr_o;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    inst_queue_2way #(.DEPTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush_i),
        .inVld0_i    (inVld0_i),
        .inVld1_i    (inVld1_i),
        .inInst0_i   (inInst0_i),
        .inInst1_i   (inInst1_i),
`ifdef INST_ADDR_TRACE_EN
        .inAddr0_i   (inAddr0_i),
        .inAddr1_i   (inAddr1_i),
        .way0Addr_o  (way0Addr_o),
        .way1Addr_o  (way1Addr_o),
`endif
        .inReady_o   (inReady_o),
        .way0Vld_o   (way0Vld_o),
        .way1Vld_o   (way1Vld_o),
        .way0Inst_o  (way0Inst_o),
        .way1Inst_o  (way1Inst_o),
        .way0Ready_i (way0Ready_i),
        .way1Ready_i (way1Ready_i),
        .count_o     (count_o)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance one edge, then return all inputs
    // idle. Outputs are sampled 1 time unit after the edge.
    task automatic cyc(input logic v0, input logic v1,
                       input logic [31:0] i0, input logic [31:0] i1,
                       input logic r0, input logic r1, input logic fl);
        inVld0_i    = v0;
        inVld1_i    = v1;
        inInst0_i   = i0;
        inInst1_i   = i1;
`ifdef INST_ADDR_TRACE_EN
        inAddr0_i   = i0 ^ 32'h8000_0000;
        inAddr1_i   = i1 ^ 32'h8000_0000;
`endif
        way0Ready_i = r0;
        way1Ready_i = r1;
        flush_i     = fl;
        @(posedge clk);
        #1;
        inVld0_i    = 1'b0;
        inVld1_i    = 1'b0;
        way0Ready_i = 1'b0;
        way1Ready_i = 1'b0;
        flush_i     = 1'b0;
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        cyc(0, 0, '0, '0, 0, 0, 0);
        cyc(0, 0, '0, '0, 0, 0, 0);
        rst = 1'b0;
        check("rst_count",  32'(count_o),   32'd0);
        check("rst_ready",  32'(inReady_o), 32'd1);
        check("rst_vld0",   32'(way0Vld_o), 32'd0);
        check("rst_vld1",   32'(way1Vld_o), 32'd0);
        check("rst_inst0",  way0Inst_o,     NOP);
        check("rst_inst1",  way1Inst_o,     NOP);
`ifdef INST_ADDR_TRACE_EN
        check("rst_addr0",  way0Addr_o,     32'd0);
`endif

        // Dual push A,B with readies low
        cyc(1, 1, A, B, 0, 0, 0);
        check("ab_inst0",   way0Inst_o,     A);
        check("ab_inst1",   way1Inst_o,     B);
        check("ab_vld0",    32'(way0Vld_o), 32'd1);
        check("ab_vld1",    32'(way1Vld_o), 32'd1);
        check("ab_count",   32'(count_o),   32'd2);
`ifdef INST_ADDR_TRACE_EN
        check("ab_addr1",   way1Addr_o,     B ^ 32'h8000_0000);
`endif

        // way1 ready without way0 ready: nothing consumed
        cyc(0, 0, '0, '0, 0, 1, 0);
        check("w1only_count", 32'(count_o), 32'd2);
        check("w1only_inst0", way0Inst_o,   A);
        check("w1only_inst1", way1Inst_o,   B);

        // Fill from empty with four dual pushes
        cyc(0, 0, '0, '0, 0, 0, 1);
        check("flush0_count", 32'(count_o), 32'd0);
        for (int k = 0; k < 4; k++) begin
            cyc(1, 1, 32'h100 + 32'(2 * k), 32'h101 + 32'(2 * k), 0, 0, 0);
        end
        check("full_count", 32'(count_o),   32'd8);
        check("full_ready", 32'(inReady_o), 32'd0);
        // Pop one while fetch offers a pair: push must be dropped
        cyc(1, 1, 32'hDEAD, 32'hBEEF, 1, 0, 0);
        check("pop7_count", 32'(count_o),   32'd7);
        check("pop7_ready", 32'(inReady_o), 32'd0);
        check("pop7_inst0", way0Inst_o,     32'h101);
        cyc(1, 1, 32'hDEAD, 32'hBEEF, 1, 0, 0);
        check("pop6_count", 32'(count_o),   32'd6);
        check("pop6_ready", 32'(inReady_o), 32'd1);
        check("pop6_inst0", way0Inst_o,     32'h102);
        check("pop6_inst1", way1Inst_o,     32'h103);

        // Wrap-around: move head/tail to 6
        cyc(0, 0, '0, '0, 0, 0, 1);
        for (int k = 0; k < 3; k++) cyc(1, 1, 32'h200 + 32'(k), 32'h210 + 32'(k), 0, 0, 0);
        for (int k = 0; k < 3; k++) cyc(0, 0, '0, '0, 1, 1, 0);
        check("wrap_empty", 32'(count_o), 32'd0);
        cyc(1, 1, C, D, 0, 0, 0);
        check("wrap_cd0",   way0Inst_o,   C);
        check("wrap_cd1",   way1Inst_o,   D);
        cyc(1, 1, E, F, 0, 0, 0);
        check("wrap_count4", 32'(count_o), 32'd4);
        // head=7: way1 must come from index 0
        cyc(0, 0, '0, '0, 1, 0, 0);
        check("wrap_h7_inst0", way0Inst_o, D);
        check("wrap_h7_inst1", way1Inst_o, E);
        cyc(0, 0, '0, '0, 1, 0, 0);
        check("wrap_ef0",    way0Inst_o,   E);
        check("wrap_ef1",    way1Inst_o,   F);
        check("wrap_count2", 32'(count_o), 32'd2);

        // Flush with count 5 plus concurrent push and pop
        cyc(0, 0, '0, '0, 0, 0, 1);
        cyc(1, 1, 32'h301, 32'h302, 0, 0, 0);
        cyc(1, 1, 32'h303, 32'h304, 0, 0, 0);
        cyc(1, 0, 32'h305, 32'h0,   0, 0, 0);
        check("fl_pre_count", 32'(count_o), 32'd5);
        cyc(1, 1, 32'h306, 32'h307, 1, 1, 1);
        check("fl_count", 32'(count_o),   32'd0);
        check("fl_vld0",  32'(way0Vld_o), 32'd0);
        check("fl_vld1",  32'(way1Vld_o), 32'd0);
        check("fl_inst0", way0Inst_o,     NOP);
        check("fl_inst1", way1Inst_o,     NOP);
        check("fl_ready", 32'(inReady_o), 32'd1);

        // inVld1 alone is ignored
        cyc(0, 1, 32'h400, 32'h401, 0, 0, 0);
        check("v1only_count", 32'(count_o), 32'd0);

        // Single push of G, then pop
        cyc(1, 0, G, 32'h0, 0, 0, 0);
        check("g_vld0",  32'(way0Vld_o), 32'd1);
        check("g_vld1",  32'(way1Vld_o), 32'd0);
        check("g_inst0", way0Inst_o,     G);
        check("g_inst1", way1Inst_o,     NOP);
        check("g_count", 32'(count_o),   32'd1);
`ifdef INST_ADDR_TRACE_EN
        check("g_addr0", way0Addr_o,     G ^ 32'h8000_0000);
        check("g_addr1", way1Addr_o,     32'd0);
`endif
        cyc(0, 0, '0, '0, 1, 1, 0);
        check("gpop_count", 32'(count_o),   32'd0);
        check("gpop_vld0",  32'(way0Vld_o), 32'd0);
        check("gpop_vld1",  32'(way1Vld_o), 32'd0);

        // Mid-operation reset behaves like flush
        cyc(1, 1, A, B, 0, 0, 0);
        rst = 1'b1;
        cyc(1, 1, C, D, 1, 1, 0);
        rst = 1'b0;
        check("rst2_count", 32'(count_o), 32'd0);
        check("rst2_inst0", way0Inst_o,   NOP);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
